msi_cache_ctrl: RTL and testbench

//  Sequencing FSM for one cache_datapath instance. Takes processor load/store

---
 rtl/msi_cache_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_msi_cache_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/msi_cache_ctrl.sv
// MSI cache sequencing FSM: turns processor load/store requests into datapath
// func/snoop controls, covering hits, dirty write-back, peer snoop fills and memory fills.
module msi_cache_ctrl #(
  parameter int unsigned SNOOP_WAIT  = 2,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       p_req,
  input  logic       p_wr,
  output logic       p_done,
  output logic       p_err,
  input  logic       read_hit,
  input  logic       write_hit,
  input  logic [1:0] stat,
  output logic [1:0] func,
  output logic       snoop_out,
  output logic       snoop_fill,
  input  logic       peer_snoop_hit,
  output logic       bus_req,
  input  logic       bus_gnt,
  input  logic       mem_ack,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WRITE  = 3'd2,
    ST_WB     = 3'd3,
    ST_SNOOP  = 3'd4,
    ST_FILL   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    F_P_READ  = 2'b00,
    F_P_WRITE = 2'b01,
    F_B_READ  = 2'b10,
    F_B_WRITE = 2'b11
  } func_e;

  localparam logic [CNT_W-1:0] SNOOP_LAST   = CNT_W'(SNOOP_WAIT);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e           state_q, state_d;
  func_e            func_q, func_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_seen_q, gnt_seen_d;
  logic             bus_req_q, bus_req_d;
  logic             p_done_q, p_done_d;
  logic             p_err_q, p_err_d;
  logic             snoop_out_q, snoop_out_d;
  logic             snoop_fill_q, snoop_fill_d;

  logic  hit;
  logic  beat_done;
  func_e beat_func;

  // write_hit implies read_hit; either one means the line is present.
  assign hit       = read_hit | write_hit;
  assign beat_done = gnt_seen_q & bus_gnt & mem_ack;
  assign beat_func = (state_q == ST_WB) ? F_B_WRITE : F_B_READ;

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    func_d       = func_q;
    cnt_d        = cnt_q;
    gnt_seen_d   = gnt_seen_q;
    bus_req_d    = bus_req_q;
    p_done_d     = 1'b0;
    p_err_d      = 1'b0;
    snoop_out_d  = 1'b0;
    snoop_fill_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        func_d = F_P_READ;
        // The cycle carrying p_done/p_err still sees the old p_req, so skip it.
        if (p_req && !p_done_q && !p_err_q) begin
          state_d = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        func_d = F_P_READ;
        if (snoop_fill_q) begin
          // Datapath loads the snooped line this cycle; look again next cycle.
          state_d = ST_LOOKUP;
        end else if (hit) begin
          if (p_wr) begin
            state_d = ST_WRITE;
            func_d  = F_P_WRITE;
          end else begin
            state_d  = ST_IDLE;
            p_done_d = 1'b1;
          end
        end else if (stat == 2'b11) begin
          state_d    = ST_WB;
          bus_req_d  = 1'b1;
          cnt_d      = '0;
          gnt_seen_d = 1'b0;
        end else begin
          state_d     = ST_SNOOP;
          snoop_out_d = 1'b1;
          cnt_d       = '0;
        end
      end

      ST_WRITE: begin
        func_d   = F_P_READ;
        p_done_d = 1'b1;
        state_d  = ST_IDLE;
      end

      ST_WB, ST_FILL: begin
        if (beat_done) begin
          func_d = F_P_READ;
          if (state_q == ST_WB) begin
            state_d     = ST_SNOOP;
            snoop_out_d = 1'b1;
            cnt_d       = '0;
          end else begin
            state_d   = ST_LOOKUP;
            bus_req_d = 1'b0;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_IDLE;
          func_d    = F_P_READ;
          bus_req_d = 1'b0;
          p_err_d   = 1'b1;
          cnt_d     = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          // A grant that later drops leaves func frozen at the beat value.
          if (!gnt_seen_q && bus_gnt) begin
            gnt_seen_d = 1'b1;
            func_d     = beat_func;
          end
        end
      end

      ST_SNOOP: begin
        func_d = F_P_READ;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == SNOOP_LAST) begin
          if (peer_snoop_hit) begin
            state_d      = ST_LOOKUP;
            snoop_fill_d = 1'b1;
            bus_req_d    = 1'b0;
          end else begin
            state_d    = ST_FILL;
            bus_req_d  = 1'b1;
            cnt_d      = '0;
            gnt_seen_d = 1'b0;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        func_d    = F_P_READ;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      func_q       <= F_P_READ;
      cnt_q        <= '0;
      gnt_seen_q   <= 1'b0;
      bus_req_q    <= 1'b0;
      p_done_q     <= 1'b0;
      p_err_q      <= 1'b0;
      snoop_out_q  <= 1'b0;
      snoop_fill_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      func_q       <= func_d;
      cnt_q        <= cnt_d;
      gnt_seen_q   <= gnt_seen_d;
      bus_req_q    <= bus_req_d;
      p_done_q     <= p_done_d;
      p_err_q      <= p_err_d;
      snoop_out_q  <= snoop_out_d;
      snoop_fill_q <= snoop_fill_d;
    end
  end

  assign p_done     = p_done_q;
  assign p_err      = p_err_q;
  assign func       = func_q;
  assign snoop_out  = snoop_out_q;
  assign snoop_fill = snoop_fill_q;
  assign bus_req    = bus_req_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_msi_cache_ctrl.sv
// Directed bench for msi_cache_ctrl: a small bus/memory/peer responder plus
// hand-computed expectations for hits, write-back, snoop fill, timeout and async reset.
module tb_msi_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       p_req, p_wr, p_done, p_err;
  logic       read_hit, write_hit;
  logic [1:0] stat, func;
  logic       snoop_out, snoop_fill, peer_snoop_hit;
  logic       bus_req, bus_gnt, mem_ack;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  msi_cache_ctrl #(.SNOOP_WAIT(2), .MEM_TIMEOUT(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_req(p_req), .p_wr(p_wr), .p_done(p_done), .p_err(p_err),
    .read_hit(read_hit), .write_hit(write_hit), .stat(stat), .func(func),
    .snoop_out(snoop_out), .snoop_fill(snoop_fill), .peer_snoop_hit(peer_snoop_hit),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .mem_ack(mem_ack), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Responder configuration, written only by the main sequence.
  bit cfg_hit, cfg_peer, cfg_ack_en;
  int cfg_gnt_dly, cfg_ack_dly;

  // Bus arbiter, memory and peer/datapath hit model.
  int gnt_cnt, ack_cnt;
  bit filled;
  always @(negedge clk) begin
    if (!rst_n) begin
      bus_gnt = 1'b0; mem_ack = 1'b0; gnt_cnt = 0; ack_cnt = 0; filled = 1'b0;
    end else begin
      if (!p_req) filled = 1'b0;
      else if (snoop_fill) filled = 1'b1;
      if (!bus_req) begin
        bus_gnt = 1'b0; gnt_cnt = 0;
      end else if (!bus_gnt) begin
        if (gnt_cnt == cfg_gnt_dly) bus_gnt = 1'b1;
        else gnt_cnt++;
      end
      if (mem_ack) begin
        mem_ack = 1'b0; ack_cnt = 0;
      end else if (bus_gnt && func[1] && cfg_ack_en) begin
        if (ack_cnt == cfg_ack_dly) begin
          mem_ack = 1'b1;
          if (func == 2'b10) filled = 1'b1;
        end else ack_cnt++;
      end else ack_cnt = 0;
    end
    read_hit       = cfg_hit | filled;
    write_hit      = 1'b0;
    peer_snoop_hit = cfg_peer;
  end

  typedef struct {
    int f01, f10, f11, breq, sout, sfill, fill_st, both;
  } stats_t;

  stats_t     mon = '{default: 0};
  stats_t     snap;
  logic [2:0] trace[$];
  logic [2:0] last_st = 3'd0;

  always @(negedge clk) begin
    if (func == 2'b01) mon.f01++;
    if (func == 2'b10) mon.f10++;
    if (func == 2'b11) mon.f11++;
    if (bus_req) mon.breq++;
    if (snoop_out) mon.sout++;
    if (snoop_fill) mon.sfill++;
    if (state_dbg == 3'd5) mon.fill_st++;
    if (p_done && p_err) mon.both++;
    if (state_dbg != last_st) begin
      trace.push_back(state_dbg);
      last_st = state_dbg;
    end
  end

  // Raise p_req and wait (bounded) for p_done or p_err; lat counts negedges.
  task automatic do_req(input logic wr, input int budget,
                        output int lat, output logic done, output logic err);
    p_wr = wr; p_req = 1'b1; lat = 0; done = 1'b0; err = 1'b0;
    while (!done && !err && lat < budget) begin
      @(negedge clk);
      lat++;
      done = p_done;
      err  = p_err;
    end
    p_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  int         lat, lat2, t0, n;
  logic       done, err;
  logic [2:0] exp_tr[7];

  initial begin
    rst_n = 1'b0; p_req = 1'b0; p_wr = 1'b0; stat = 2'b00;
    cfg_hit = 0; cfg_peer = 0; cfg_ack_en = 0; cfg_gnt_dly = 0; cfg_ack_dly = 0;
    repeat (3) @(negedge clk);
    check("rst_state", state_dbg, 0);
    check("rst_func", func, 0);
    check("rst_outs", {p_done, p_err, snoop_out, snoop_fill, bus_req}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_hold", state_dbg, 0);

    // Load hit followed immediately by a second load hit.
    cfg_hit = 1; stat = 2'b10;
    @(negedge clk);
    snap = mon;
    do_req(1'b0, 40, lat, done, err);
    do_req(1'b0, 40, lat2, done, err);
    check("ld_hit_lat", lat, 2);
    check("b2b_lat", lat2, 3);
    check("ld_hit_done", done, 1);
    @(negedge clk);
    check("ld_done_pulse", p_done, 0);
    check("ld_state_idle", state_dbg, 0);
    check("ld_func_zero", (mon.f01 - snap.f01) + (mon.f10 - snap.f10) + (mon.f11 - snap.f11), 0);
    check("ld_no_bus", mon.breq - snap.breq, 0);

    // Store hit.
    @(negedge clk);
    snap = mon;
    do_req(1'b1, 40, lat, done, err);
    @(negedge clk);
    check("st_hit_lat", lat, 3);
    check("st_hit_f01", mon.f01 - snap.f01, 1);

    // Load miss served by the peer cache.
    cfg_hit = 0; cfg_peer = 1; stat = 2'b10;
    @(negedge clk);
    snap = mon;
    do_req(1'b0, 40, lat, done, err);
    @(negedge clk);
    check("snp_lat", lat, 7);
    check("snp_done", {done, err}, 2'b10);
    check("snp_fill_cyc", mon.sfill - snap.sfill, 1);
    check("snp_out_cyc", mon.sout - snap.sout, 1);
    check("snp_no_bfunc", (mon.f10 - snap.f10) + (mon.f11 - snap.f11), 0);
    check("snp_no_bus", mon.breq - snap.breq, 0);

    // Store miss with dirty victim: WB, SNOOP, FILL, LOOKUP, WRITE.
    cfg_peer = 0; cfg_ack_en = 1; cfg_gnt_dly = 3; cfg_ack_dly = 2; stat = 2'b11;
    @(negedge clk);
    snap = mon;
    t0 = trace.size();
    do_req(1'b1, 80, lat, done, err);
    @(negedge clk);
    check("wb_done", {done, err}, 2'b10);
    check("wb_f11_cyc", mon.f11 - snap.f11, 3);
    check("wb_f10_cyc", mon.f10 - snap.f10, 3);
    check("wb_f01_cyc", mon.f01 - snap.f01, 1);
    exp_tr[0] = 3'd1; exp_tr[1] = 3'd3; exp_tr[2] = 3'd4; exp_tr[3] = 3'd5;
    exp_tr[4] = 3'd1; exp_tr[5] = 3'd2; exp_tr[6] = 3'd0;
    n = trace.size() - t0;
    check("wb_trace_len", n, 7);
    for (int i = 0; i < 7 && i < n; i++) check($sformatf("wb_trace_%0d", i), trace[t0 + i], exp_tr[i]);

    // Fill that never gets mem_ack: timeout after 8 waiting cycles.
    cfg_ack_en = 0; cfg_gnt_dly = 0; stat = 2'b00;
    @(negedge clk);
    snap = mon;
    do_req(1'b0, 60, lat, done, err);
    check("to_err", {done, err}, 2'b01);
    check("to_outs", {bus_req, func, p_done}, 0);
    check("to_state", state_dbg, 0);
    @(negedge clk);
    check("to_err_pulse", p_err, 0);
    check("to_fill_cyc", mon.fill_st - snap.fill_st, 8);
    check("to_f10_cyc", mon.f10 - snap.f10, 7);

    // Asynchronous reset in the middle of a write-back beat.
    stat = 2'b11;
    @(negedge clk);
    p_wr = 1'b1; p_req = 1'b1;
    for (int i = 0; i < 20 && func != 2'b11; i++) @(negedge clk);
    check("ar_in_wb", {state_dbg, func}, {3'd3, 2'b11});
    #2 rst_n = 1'b0;
    #1;
    check("ar_bus_req", bus_req, 0);
    check("ar_func", func, 0);
    check("ar_snoop_out", snoop_out, 0);
    check("ar_state", state_dbg, 0);
    p_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cfg_hit = 1; stat = 2'b10;
    @(negedge clk);
    do_req(1'b0, 40, lat, done, err);
    check("ar_ld_lat", lat, 2);
    check("ar_ld_done", {done, err}, 2'b10);

    @(negedge clk);
    check("done_err_overlap", mon.both, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
